// File: rtl/adc_capture_packer.sv
// rtl/adc_capture_packer.sv - ADC sample capture with decimation, test ramp and FWFT FIFO onto AXI-Stream.
// Emits exactly the latched dsize beats per start; overflowed sets are retried by later sets.
module adc_capture_packer #(
   parameter int NCH   = 2,
   parameter int SW    = 16,
   parameter int DEPTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  s_valid,
   input  logic [NCH*SW-1:0]     s_data,
   input  logic                  cfg_start,
   input  logic                  cfg_test,
   input  logic [31:0]           cfg_dsize,
   input  logic [7:0]            cfg_decim,
   output logic                  sr_busy,
   output logic                  sr_done,
   output logic                  sr_ovf,
   output logic                  m00_axis_tvalid,
   output logic [NCH*SW-1:0]     m00_axis_tdata,
   output logic [NCH*SW/8-1:0]   m00_axis_tkeep,
   output logic                  m00_axis_tlast,
   input  logic                  m00_axis_tready
);
   localparam int DW = NCH * SW;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

   state_t          r_state, w_next;
   logic [31:0]     r_dsize, r_wr_cnt, r_beat_cnt;
   logic [7:0]      r_decim, r_dec_cnt;
   logic            r_ovf, r_done;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_fill;

   logic            w_start, w_keep, w_full, w_push, w_drop, w_pop;
   logic [DW-1:0]   w_ramp, w_wdata;

   // Ramp index is the written-set count, so sets lost to overflow leave no gap.
   for (genvar gk = 0; gk < NCH; gk++) begin : g_ramp
      logic [31:0] w_rv;
      assign w_rv = r_wr_cnt * 32'(NCH) + 32'(gk);
      assign w_ramp[gk*SW +: SW] = w_rv[SW-1:0];
   end

   assign w_wdata = cfg_test ? w_ramp : s_data;
   assign w_keep  = (r_state == S_CAPTURE) && s_valid && (r_dec_cnt == 8'd0);
   assign w_full  = (r_fill == (AW+1)'(DEPTH));
   assign w_push  = w_keep && !w_full;
   assign w_drop  = w_keep && w_full;
   assign w_pop   = m00_axis_tvalid && m00_axis_tready;
   assign w_start = (r_state == S_IDLE) && (w_next == S_CAPTURE);

   assign m00_axis_tvalid = (r_fill != '0);
   assign m00_axis_tdata  = m00_axis_tvalid ? r_mem[r_rptr] : '0;
   assign m00_axis_tkeep  = m00_axis_tvalid ? '1 : '0;
   assign m00_axis_tlast  = m00_axis_tvalid && (r_beat_cnt == r_dsize - 32'd1);
   assign sr_busy         = (r_state != S_IDLE);
   assign sr_done         = r_done;
   assign sr_ovf          = r_ovf;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (cfg_start && (cfg_dsize != 32'd0)) w_next = S_CAPTURE;
         S_CAPTURE: if (w_push && (r_wr_cnt == r_dsize - 32'd1)) w_next = S_DRAIN;
         S_DRAIN:   if (w_pop && m00_axis_tlast) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_dsize    <= '0;
         r_decim    <= '0;
         r_wr_cnt   <= '0;
         r_beat_cnt <= '0;
         r_dec_cnt  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_fill     <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_DRAIN) && (w_next == S_IDLE);
         if (w_start) begin
            r_dsize    <= cfg_dsize;
            r_decim    <= cfg_decim;
            r_wr_cnt   <= '0;
            r_beat_cnt <= '0;
            r_dec_cnt  <= '0;
            r_ovf      <= 1'b0;
         end else begin
            if ((r_state == S_CAPTURE) && s_valid)
               r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
            if (w_push) r_wr_cnt <= r_wr_cnt + 32'd1;
            if (w_pop)  r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_drop) r_ovf <= 1'b1;
         end
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_push) r_mem[r_wptr] <= w_wdata;
   end
endmodule

// File: tb/tb_adc_capture_packer.sv
// tb/tb_adc_capture_packer.sv - randomized and directed bench for adc_capture_packer.
// Reference model is a queue of expected beats driven by the capture rules.
module tb_adc_capture_packer;
   localparam int NCH = 2, SW = 16, DEPTH = 16;
   localparam int DW = NCH * SW, KW = DW / 8;

   logic            ACLK, ARESETN, s_valid, cfg_start, cfg_test;
   logic [DW-1:0]   s_data;
   logic [31:0]     cfg_dsize;
   logic [7:0]      cfg_decim;
   logic            sr_busy, sr_done, sr_ovf;
   logic            m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;
   logic [DW-1:0]   m00_axis_tdata;
   logic [KW-1:0]   m00_axis_tkeep;

   adc_capture_packer #(.NCH(NCH), .SW(SW), .DEPTH(DEPTH)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_valid(s_valid), .s_data(s_data),
      .cfg_start(cfg_start), .cfg_test(cfg_test), .cfg_dsize(cfg_dsize), .cfg_decim(cfg_decim),
      .sr_busy(sr_busy), .sr_done(sr_done), .sr_ovf(sr_ovf),
      .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
      .m00_axis_tkeep(m00_axis_tkeep), .m00_axis_tlast(m00_axis_tlast),
      .m00_axis_tready(m00_axis_tready)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int n_cmp = 0, n_bad = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;
   logic [DW-1:0] got[$];
   bit got_last[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: phase 0 idle, 1 capturing, 2 draining.
   logic [DW-1:0] q[$];
   int unsigned m_dsize = 0, m_decim = 0, m_vcnt = 0, m_written = 0, m_xfer = 0;
   int m_phase = 0;
   bit m_ovf = 1'b0, m_done = 1'b0;

   always @(posedge ACLK) begin : model
      int ph0;
      bit full, keep;
      logic [DW-1:0] v;
      logic [31:0] t;
      if (!ARESETN) begin
         q.delete();
         m_phase = 0; m_ovf = 1'b0; m_done = 1'b0; m_dsize = 0; m_xfer = 0;
      end else begin
         ph0  = m_phase;
         full = (q.size() == DEPTH);
         m_done = 1'b0;
         if (q.size() > 0 && m00_axis_tready) begin
            void'(q.pop_front());
            m_xfer++;
            if (m_phase == 2 && m_xfer == m_dsize) begin
               m_phase = 0;
               m_done  = 1'b1;
            end
         end
         if (ph0 == 1 && s_valid) begin
            keep = ((m_vcnt % (m_decim + 1)) == 0);
            m_vcnt++;
            if (keep) begin
               if (full) m_ovf = 1'b1;
               else begin
                  for (int k = 0; k < NCH; k++) begin
                     t = m_written * NCH + k;
                     v[k*SW +: SW] = t[SW-1:0];
                  end
                  q.push_back(cfg_test ? v : s_data);
                  m_written++;
                  if (m_written == m_dsize) m_phase = 2;
               end
            end
         end
         if (ph0 == 0 && cfg_start && cfg_dsize != 0) begin
            m_phase = 1; m_dsize = cfg_dsize; m_decim = cfg_decim;
            m_vcnt = 0; m_written = 0; m_xfer = 0; m_ovf = 1'b0;
         end
      end
   end

   always @(negedge ACLK) begin : compare
      bit ev;
      if (chk_en) begin
         ev = (q.size() > 0);
         chk("tvalid", m00_axis_tvalid, ev);
         chk("tdata", m00_axis_tdata, ev ? q[0] : '0);
         chk("tlast", m00_axis_tlast, ev && (m_xfer == m_dsize - 1));
         chk("tkeep", m00_axis_tkeep, ev ? {KW{1'b1}} : '0);
         chk("busy", sr_busy, m_phase != 0);
         chk("done", sr_done, m_done);
         chk("ovf", sr_ovf, m_ovf);
         if (m00_axis_tvalid && m00_axis_tready) begin
            got.push_back(m00_axis_tdata);
            got_last.push_back(m00_axis_tlast);
         end
         if (sr_done) done_cnt++;
      end
   end

   int valid_mode = 0, ready_mode = 0;
   logic [DW-1:0] data_cnt = '0;

   task automatic step();
      @(posedge ACLK);
      #1;
      cfg_start = 1'b0;
      case (valid_mode)
         1:       begin s_valid = 1'b1; s_data = data_cnt; data_cnt = data_cnt + 1'b1; end
         2:       begin s_valid = 1'($urandom_range(0, 1)); s_data = DW'($urandom); end
         default: s_valid = 1'b0;
      endcase
      case (ready_mode)
         1:       m00_axis_tready = 1'b1;
         2:       m00_axis_tready = 1'($urandom_range(0, 1));
         default: m00_axis_tready = 1'b0;
      endcase
   endtask

   task automatic start(input logic [31:0] dsize, input logic [7:0] decim, input logic test);
      cfg_dsize = dsize; cfg_decim = decim; cfg_test = test; cfg_start = 1'b1;
   endtask

   task automatic clear_got();
      got.delete();
      got_last.delete();
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      chk({name, "_done_seen"}, done_cnt != d0, 1);
      step();
      step();
   endtask

   task automatic chk_ramp(input string name, input int n);
      int lasts = 0;
      chk({name, "_beats"}, got.size(), n);
      for (int i = 0; i < got.size() && i < n; i++) begin
         chk({name, "_beat"}, got[i], 32'h0001_0000 + i * 32'h0002_0002);
         lasts += got_last[i];
      end
      if (got.size() >= n) chk({name, "_tlast_end"}, got_last[n-1], 1);
      chk({name, "_tlast_cnt"}, lasts, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin : main
      int d0, n;
      ARESETN = 1'b0; s_valid = 1'b0; s_data = '0; cfg_start = 1'b0; cfg_test = 1'b0;
      cfg_dsize = '0; cfg_decim = '0; m00_axis_tready = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      step();
      chk("rst_tvalid", m00_axis_tvalid, 0);
      chk("rst_tdata", m00_axis_tdata, 0);
      chk("rst_tkeep", m00_axis_tkeep, 0);
      chk("rst_busy", sr_busy, 0);
      ARESETN = 1'b1;
      step();

      // Ramp, no decimation, free-running sink.
      valid_mode = 1; ready_mode = 1; clear_got(); d0 = done_cnt;
      step(); start(8, 0, 1);
      wait_done(200, "t1");
      chk_ramp("t1", 8);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_ovf", sr_ovf, 0);

      // Decimation by 3 on counting input data.
      clear_got();
      step(); start(5, 2, 0); s_valid = 1'b0; data_cnt = '0;
      wait_done(200, "t2");
      chk("t2_beats", got.size(), 5);
      for (int i = 0; i < got.size() && i < 5; i++) chk("t2_beat", got[i], 3 * i);

      // Stalled sink forces overflow; the ramp must still be contiguous.
      clear_got(); ready_mode = 0;
      step(); start(32, 0, 1);
      repeat (40) step();
      ready_mode = 1;
      wait_done(300, "t3");
      chk_ramp("t3", 32);
      chk("t3_ovf", sr_ovf, 1);

      // Zero-size start is ignored and leaves the sticky flag alone.
      d0 = done_cnt;
      step(); start(0, 0, 1);
      step(); step();
      chk("t6a_busy", sr_busy, 0);
      chk("t6a_ovf", sr_ovf, 1);
      chk("t6a_done", done_cnt - d0, 0);

      // Random valid and ready.
      clear_got(); valid_mode = 2; ready_mode = 2;
      step(); start(100, 1, 0);
      wait_done(3000, "t4");
      chk("t4_beats", got.size(), 100);
      if (got.size() == 100) chk("t4_tlast", got_last[99], 1);

      // Reset mid-drain, then a clean capture.
      valid_mode = 1; ready_mode = 1; clear_got(); d0 = done_cnt;
      step(); start(20, 0, 1);
      n = 0;
      while (got.size() < 10 && n < 100) begin step(); n++; end
      chk("t5_reached_10", got.size() >= 10, 1);
      ARESETN = 1'b0;
      step();
      chk("t5_rst_tvalid", m00_axis_tvalid, 0);
      chk("t5_rst_tlast", m00_axis_tlast, 0);
      chk("t5_rst_tdata", m00_axis_tdata, 0);
      chk("t5_rst_busy", sr_busy, 0);
      ARESETN = 1'b1;
      repeat (5) step();
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_idle_tvalid", m00_axis_tvalid, 0);
      clear_got();
      step(); start(4, 0, 1);
      wait_done(100, "t5b");
      chk_ramp("t5b", 4);

      // Start during capture is ignored.
      clear_got(); d0 = done_cnt;
      step(); start(6, 0, 1);
      step(); step(); start(3, 0, 1);
      wait_done(100, "t6b");
      chk_ramp("t6b", 6);
      chk("t6b_done_cnt", done_cnt - d0, 1);

      valid_mode = 0; ready_mode = 0;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/adc_capture_packer.md
# adc_capture_packer

Parametrised capture engine between the ADC deserialiser and the AXI-Stream master port. Takes NCH parallel channel samples per valid strobe, optionally decimates or replaces them with a test ramp, and buffers them in a FIFO. On a start command it emits exactly cfg_dsize beats with TLAST on the final beat. It reports busy, done and sticky overflow status to the AXI-lite register block.

## Interface
Parameters:
- NCH, 2: channel count, 1..4.
- SW, 16: sample width in bits, multiple of 8, 8..32.
- DEPTH, 16: FIFO depth in beats, power of two, at least 4.

Ports:
- ACLK  in  1  sole clock; all logic rising-edge.
- ARESETN  in  1  reset, synchronous, active-low.
- s_valid  in  1  sample-set strobe, no backpressure.
- s_data  in  NCH*SW  channel k at bits [k*SW +: SW].
- cfg_start  in  1  one-cycle start pulse.
- cfg_test  in  1  level; 1 selects the test ramp instead of s_data.
- cfg_dsize  in  32  beats per capture, sampled at start.
- cfg_decim  in  8  keep 1 of every cfg_decim+1 valid sets, sampled at start.
- sr_busy  out  1  capture or drain in progress.
- sr_done  out  1  one-cycle pulse at capture completion.
- sr_ovf  out  1  sticky overflow flag; cleared by an accepted start.
- m00_axis_tvalid  out  1  FIFO not empty.
- m00_axis_tdata  out  NCH*SW  FIFO head.
- m00_axis_tkeep  out  NCH*SW/8  all ones.
- m00_axis_tlast  out  1  high on beat index dsize-1.
- m00_axis_tready  in  1  sink ready.

## Operation
- FSM states:
  - IDLE:
    - cfg_start with cfg_dsize != 0 -> CAPTURE.
    - On entry to CAPTURE: latch dsize and decim; clear the write count, output beat count, decimation count, ramp count and sr_ovf.
    - cfg_start with cfg_dsize == 0 is ignored: no done, sr_ovf unchanged.
  - CAPTURE: each kept set is pushed into the FIFO. When written count == dsize -> DRAIN.
  - DRAIN: once the beat with tlast is transferred (tvalid & tready) -> IDLE, sr_done pulses for 1 cycle.
- cfg_start is ignored in CAPTURE and DRAIN.
- Decimation:
  - The counter starts at 0 on start and counts valid sets modulo decim+1.
  - A set is kept when the counter == 0, so the first valid after start is kept.
  - decim = 0 keeps every set.
- Test ramp: channel k of kept set n = (n*NCH + k) mod 2^SW, where n = kept-set index since start. n advances only on kept sets and is not advanced by dropped sets.
- Overflow:
  - A kept set arriving while the FIFO is full is dropped. A simultaneous read the same cycle does not free space for it.
  - The dropped set sets sr_ovf and does not increment the write count. Capture therefore still produces dsize beats, later in time.
- Valid sets outside CAPTURE are discarded.
- The beat counter increments per transfer. tlast = (beat count == dsize-1) & tvalid.
- Arithmetic: 32-bit counters, no wrap within a legal capture. dsize up to 2^32-1 is supported.

## Timing
- Reset values: tvalid 0, tlast 0, tdata 0, sr_busy 0, sr_done 0, sr_ovf 0, FSM IDLE, FIFO empty.
- Reset mid-operation aborts the capture and flushes the FIFO; no sr_done pulse is issued.
- sr_busy rises the cycle after an accepted start and falls in the same cycle sr_done pulses.
- FIFO is first-word-fall-through:
  - A set pushed at edge t appears on tvalid/tdata from t+1 (1-cycle latency when empty).
  - tdata holds stable while tvalid=1 and tready=0.
- Throughput: 1 beat/cycle sustained with tready held high.
- tkeep is constant all-ones whenever tvalid=1 and 0 in reset.

## Test plan
- NCH=2, SW=16, test=1, dsize=8, decim=0, s_valid continuous, tready=1:
  - beats 0x00010000, 0x00030002 … 0x000F000E;
  - tlast only on beat 8; sr_done pulses once; sr_ovf=0.
- dsize=5, decim=2, test=0, s_data = counter incremented per valid: beats carry input sets 0, 3, 6, 9, 12.
- tready=0 for 40 cycles, DEPTH=16, dsize=32, continuous valid:
  - sr_ovf=1;
  - exactly 32 beats are still emitted after tready returns, with tlast on the 32nd;
  - the ramp shows no gaps.
- Random tready (50%) with dsize=100: no beat lost or duplicated; tdata stable while stalled.
- ARESETN low for 1 cycle at beat 10 of 20: all outputs return to reset values the next cycle; FIFO empty; no sr_done. A new start then runs cleanly.
- Boundary commands:
  - start with dsize=0: no state change.
  - second start during CAPTURE: ignored, and the beat count stays at the original dsize.
